uart_transmitter: RTL and testbench

UART_TRANSMITTER -- requirements
Module: transmitter

---
 rtl/uart_transmitter.sv | 206 ++++++++++++++++++++
 tb/tb_uart_transmitter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1/8N2 UART transmitter with a valid/ready byte interface.
// Frame: start bit (0), data bits 0..7 LSB first, optional even parity bit,
// STOP_BITS stop bits (1). Each bit is held for CLKS_PER_BIT clk cycles.
// Optional feature macro: UART_TX_PARITY_EN adds a PARITY state that sends
// the even parity (XOR) of the captured byte between the data and stop bits.
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (2..256)
//   STOP_BITS     number of stop bits (1 or 2)
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   data_in        byte to transmit
//   data_in_valid  host presents a byte on data_in
//   data_in_ready  transmitter idle and able to accept a byte
//   tx_bitstream   serial line, registered, idle high
//   active_tx      high while a frame is being driven
//   done           one-cycle pulse on the last cycle of the final stop bit
module uart_transmitter #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data_in,
   input  logic       data_in_valid,
   output logic       data_in_ready,
   output logic       tx_bitstream,
   output logic       active_tx,
   output logic       done
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   // done is registered, so it is launched one cycle before the final bit cycle
   localparam logic [CW-1:0] CNT_PRE_LAST = CW'(CLKS_PER_BIT - 2);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd4
   } state_t;
`endif

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic          stop_q, stop_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          tx_q, tx_d;
   logic          active_q, active_d;
   logic          done_q, done_d;
   logic          ready_q, ready_d;
`ifdef UART_TX_PARITY_EN
   logic          par_q, par_d;
`endif

   logic bit_wrap_c;
   logic last_stop_c;

   assign bit_wrap_c  = (cnt_q == CNT_LAST);
   assign last_stop_c = (STOP_BITS < 2) || stop_q;

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         stop_q   <= 1'b0;
         shreg_q  <= '0;
         tx_q     <= 1'b1;
         active_q <= 1'b0;
         done_q   <= 1'b0;
         ready_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         stop_q   <= stop_d;
         shreg_q  <= shreg_d;
         tx_q     <= tx_d;
         active_q <= active_d;
         done_q   <= done_d;
         ready_q  <= ready_d;
`ifdef UART_TX_PARITY_EN
         par_q    <= par_d;
`endif
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = bit_wrap_c ? '0 : cnt_q + CW'(1);
      bit_d    = bit_q;
      stop_d   = stop_q;
      shreg_d  = shreg_q;
      tx_d     = tx_q;
      active_d = active_q;
      done_d   = 1'b0;
      ready_d  = ready_q;
`ifdef UART_TX_PARITY_EN
      par_d    = par_q;
`endif

      case (state_q)
         IDLE: begin
            cnt_d    = '0;
            bit_d    = '0;
            stop_d   = 1'b0;
            tx_d     = 1'b1;
            active_d = 1'b0;
            ready_d  = 1'b1;
            if (data_in_valid) begin
               shreg_d  = data_in;
`ifdef UART_TX_PARITY_EN
               par_d    = ^data_in;
`endif
               state_d  = START;
               tx_d     = 1'b0;
               active_d = 1'b1;
               ready_d  = 1'b0;
            end
         end

         START: begin
            if (bit_wrap_c) begin
               state_d = DATA;
               bit_d   = '0;
               tx_d    = shreg_q[0];
            end
         end

         DATA: begin
            if (bit_wrap_c) begin
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
                  tx_d    = par_q;
`else
                  state_d = STOP;
                  stop_d  = 1'b0;
                  tx_d    = 1'b1;
`endif
               end else begin
                  // Shift right so the next data bit is always at shreg_q[1]
                  bit_d   = bit_q + 3'd1;
                  shreg_d = {1'b0, shreg_q[7:1]};
                  tx_d    = shreg_q[1];
               end
            end
         end

`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_wrap_c) begin
               state_d = STOP;
               stop_d  = 1'b0;
               tx_d    = 1'b1;
            end
         end
`endif

         STOP: begin
            done_d = last_stop_c && (cnt_q == CNT_PRE_LAST);
            if (bit_wrap_c) begin
               if (last_stop_c) begin
                  state_d  = IDLE;
                  tx_d     = 1'b1;
                  active_d = 1'b0;
                  ready_d  = 1'b1;
               end else begin
                  stop_d = 1'b1;
               end
            end
         end

         default: begin
            state_d  = IDLE;
            cnt_d    = '0;
            tx_d     = 1'b1;
            active_d = 1'b0;
            ready_d  = 1'b1;
         end
      endcase
   end

   assign data_in_ready = ready_q;
   assign tx_bitstream  = tx_q;
   assign active_tx     = active_q;
   assign done          = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: a default instance (16 clk/bit, 1 stop)
// and a fast instance (4 clk/bit, 2 stop bits). Expected serial waveforms are
// derived from the byte value and the frame layout by exp_tx().
module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic       valid_a = 1'b0;
   logic       valid_b = 1'b0;
   logic       ready_a, tx_a, act_a, done_a;
   logic       ready_b, tx_b, act_b, done_b;
   logic       sel = 1'b0;
   logic       rdy_m, tx_m, act_m, done_m;

   int  checks = 0;
   int  errors = 0;
   time last_acc = 0;

   uart_transmitter #(.CLKS_PER_BIT(16), .STOP_BITS(1)) dut_a (
      .clk           (clk),
      .rst_n         (rst_n),
      .data_in       (data_in),
      .data_in_valid (valid_a),
      .data_in_ready (ready_a),
      .tx_bitstream  (tx_a),
      .active_tx     (act_a),
      .done          (done_a)
   );

   uart_transmitter #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut_b (
      .clk           (clk),
      .rst_n         (rst_n),
      .data_in       (data_in),
      .data_in_valid (valid_b),
      .data_in_ready (ready_b),
      .tx_bitstream  (tx_b),
      .active_tx     (act_b),
      .done          (done_b)
   );

   assign rdy_m  = sel ? ready_b : ready_a;
   assign tx_m   = sel ? tx_b    : tx_a;
   assign act_m  = sel ? act_b   : act_a;
   assign done_m = sel ? done_b  : done_a;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_valid(input logic v);
      if (sel) valid_b = v;
      else     valid_a = v;
   endtask

   // Expected line level in cycle k (k=1 is the first cycle after acceptance)
   function automatic logic exp_tx(input logic [7:0] b, input int k, input int cpb);
      int slot;
      slot = (k - 1) / cpb;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return b[3'(slot - 1)];
      if (PAR == 1 && slot == 9) return ^b;
      return 1'b1;
   endfunction

   // Called in the acceptance cycle with valid already high; checks every
   // cycle of the frame plus the following idle cycle.
   task automatic frame(input logic [7:0] b, input int cpb, input int ns,
                        input logic keep, input logic [7:0] next_d,
                        input int inject_k, input int abort_k, input logic chk_per);
      int   last;
      logic aborted;
      last    = (9 + PAR + ns) * cpb;
      aborted = 1'b0;
      chk($sformatf("ready_accept_%h", b), rdy_m, 1'b1);
      @(posedge clk);
      if (chk_per) chk_int("accept_period", int'(($time - last_acc) / 10), last + 1);
      last_acc = $time;
      #1;
      set_valid(keep);
      data_in = next_d;
      for (int k = 1; k <= last; k++) begin
         @(negedge clk);
         chk($sformatf("tx_%h_k%0d", b, k), tx_m, exp_tx(b, k, cpb));
         chk($sformatf("active_%h_k%0d", b, k), act_m, 1'b1);
         chk($sformatf("done_%h_k%0d", b, k), done_m, k == last);
         chk($sformatf("ready_%h_k%0d", b, k), rdy_m, 1'b0);
         if (k == inject_k) begin
            data_in = 8'hFF;
            set_valid(1'b1);
         end
         if (k == inject_k + 1) set_valid(1'b0);
         if (k == abort_k) begin
            #2 rst_n = 1'b0;
            #1;
            chk("abort_tx", tx_m, 1'b1);
            chk("abort_active", act_m, 1'b0);
            chk("abort_done", done_m, 1'b0);
            chk("abort_ready", rdy_m, 1'b1);
            aborted = 1'b1;
            break;
         end
      end
      if (!aborted) begin
         @(negedge clk);
         chk($sformatf("idle_tx_%h", b), tx_m, 1'b1);
         chk($sformatf("idle_active_%h", b), act_m, 1'b0);
         chk($sformatf("idle_done_%h", b), done_m, 1'b0);
         chk($sformatf("idle_ready_%h", b), rdy_m, 1'b1);
      end
   endtask

   initial begin
      // Asynchronous reset, before any clock edge
      #2 rst_n = 1'b0;
      #1;
      chk("rst_tx", tx_a, 1'b1);
      chk("rst_active", act_a, 1'b0);
      chk("rst_done", done_a, 1'b0);
      chk("rst_ready", ready_a, 1'b1);
      chk("rst_tx_b", tx_b, 1'b1);
      repeat (3) @(negedge clk);

      // 8'h55 accepted on the first edge after reset release, valid for one cycle
      rst_n   = 1'b1;
      data_in = 8'h55;
      valid_a = 1'b1;
      frame(8'h55, 16, 1, 1'b0, 8'h00, -1, -1, 1'b0);

      // Valid held: 8'hA3 then 8'h0F, back to back with one idle cycle
      data_in = 8'hA3;
      valid_a = 1'b1;
      frame(8'hA3, 16, 1, 1'b1, 8'h0F, -1, -1, 1'b0);
      frame(8'h0F, 16, 1, 1'b0, 8'h00, -1, -1, 1'b1);

      // New byte offered mid-frame must be ignored
      data_in = 8'h3C;
      valid_a = 1'b1;
      frame(8'h3C, 16, 1, 1'b0, 8'h3C, 50, -1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk($sformatf("no_frame_tx_%0d", i), tx_a, 1'b1);
         chk($sformatf("no_frame_active_%0d", i), act_a, 1'b0);
      end

      // Reset in the middle of a frame, then a clean 8'hFF frame
      data_in = 8'hC5;
      valid_a = 1'b1;
      frame(8'hC5, 16, 1, 1'b0, 8'h00, -1, 80, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("held_rst_tx", tx_a, 1'b1);
      chk("held_rst_active", act_a, 1'b0);
      @(negedge clk);
      rst_n   = 1'b1;
      data_in = 8'hFF;
      valid_a = 1'b1;
      frame(8'hFF, 16, 1, 1'b0, 8'h00, -1, -1, 1'b0);

      // Odd and even popcount bytes (parity bit 1 and 0 when parity is built in)
      data_in = 8'h07;
      valid_a = 1'b1;
      frame(8'h07, 16, 1, 1'b0, 8'h00, -1, -1, 1'b0);
      data_in = 8'h03;
      valid_a = 1'b1;
      frame(8'h03, 16, 1, 1'b0, 8'h00, -1, -1, 1'b0);

      // Fast instance: 4 clk/bit, two stop bits, MSB set
      sel     = 1'b1;
      data_in = 8'h80;
      valid_b = 1'b1;
      frame(8'h80, 4, 2, 1'b0, 8'h00, -1, -1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
